// File: rtl/param_modulator_pkg.sv
// Shared types and constants for the param_modulator carrier modulator.
package param_modulator_pkg;

  localparam logic [1:0] MODE_ASK    = 2'b00;
  localparam logic [1:0] MODE_FSK    = 2'b01;
  localparam logic [1:0] MODE_BPSK   = 2'b10;
  localparam logic [1:0] MODE_SILENT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic int midscale(input int w);
    return int'(32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/sine_lut.sv
// Combinational full-wave offset-binary sine table, one carrier period
// over 2^LUT_AW entries; entry 0 is midscale and the peak is 2^OUT_W-1.
module sine_lut
  import param_modulator_pkg::*;
#(
  parameter int LUT_AW = 6,
  parameter int OUT_W  = 8
) (
  input  logic [LUT_AW-1:0] addr_i,
  output logic [OUT_W-1:0]  data_o
);

  localparam int  DEPTH = int'(32'd1 << LUT_AW);
  localparam real PI    = 3.14159265358979323846;

  // Amplitude is midscale-1 so that the positive peak lands exactly on all-ones.
  function automatic logic [OUT_W-1:0] sine_entry(input int idx);
    real amp;
    real v;
    amp = real'(midscale(OUT_W) - 1);
    v   = real'(midscale(OUT_W)) + amp * $sin(2.0 * PI * real'(idx) / real'(DEPTH)) + 0.5;
    return OUT_W'($rtoi(v));
  endfunction

  logic [OUT_W-1:0] table_s [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    assign table_s[g] = sine_entry(g);
  end

  assign data_o = table_s[addr_i];

endmodule

// File: rtl/param_modulator.sv
// ASK/FSK/BPSK frame modulator. Define PARAM_MODULATOR_REPEAT_EN to let a held
// start chain frames back-to-back; otherwise start must drop low between frames.
module param_modulator
  import param_modulator_pkg::*;
#(
  parameter int MSG_W  = 10,
  parameter int OUT_W  = 8,
  parameter int SPS    = 16,
  parameter int LUT_AW = 6,
  parameter int INC_F0 = 1,
  parameter int INC_F1 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MSG_W-1:0] msg,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             bit_out
);

  localparam int SCW = $clog2(SPS);
  localparam int BCW = (MSG_W > 1) ? $clog2(MSG_W) : 1;
  localparam logic [OUT_W-1:0] MID     = OUT_W'(midscale(OUT_W));
  localparam logic [SCW-1:0]   SC_LAST = SCW'(SPS - 1);
  localparam logic [BCW-1:0]   BC_LAST = BCW'(MSG_W - 1);

  state_t            state_q;
  logic [1:0]        mode_q;
  logic [MSG_W-1:0]  shreg_q;
  logic [SCW-1:0]    sc_q;
  logic [BCW-1:0]    bc_q;
  logic [LUT_AW-1:0] phase_q;
  logic [OUT_W-1:0]  out_q;
  logic              busy_q;
  logic              done_q;
  logic              bit_out_q;

  logic [OUT_W-1:0]  lut_s;
  logic              launch_s;
  logic              arm_ok_s;
  logic              last_s;
  logic              next_bit_s;

  function automatic logic [OUT_W-1:0] shape_sample(input logic [1:0] md, input logic b,
                                                    input logic [OUT_W-1:0] s);
    case (md)
      MODE_ASK:  return b ? s : MID;
      MODE_FSK:  return s;
      MODE_BPSK: return b ? s : ~s;
      default:   return MID;
    endcase
  endfunction

  function automatic logic [LUT_AW-1:0] phase_inc(input logic [1:0] md, input logic b);
    if (md == MODE_FSK) begin
      return b ? LUT_AW'(INC_F1) : LUT_AW'(INC_F0);
    end else begin
      return LUT_AW'(1);
    end
  endfunction

  sine_lut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_sine_lut (
    .addr_i (phase_q),
    .data_o (lut_s)
  );

`ifndef PARAM_MODULATOR_REPEAT_EN
  logic armed_q;

  // Re-arm once start is seen low; disarm on every frame launch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q <= 1'b1;
    end else if (launch_s) begin
      armed_q <= 1'b0;
    end else if (!start) begin
      armed_q <= 1'b1;
    end else begin
      armed_q <= armed_q;
    end
  end

  assign arm_ok_s = armed_q;
`else
  assign arm_ok_s = 1'b1;
`endif

  // Frame launch decision; with repeat enabled a held start chains out of DONE.
  always_comb begin
    launch_s = 1'b0;
    case (state_q)
      ST_IDLE: launch_s = start && arm_ok_s;
`ifdef PARAM_MODULATOR_REPEAT_EN
      ST_DONE: launch_s = start;
`endif
      default: launch_s = 1'b0;
    endcase
  end

  assign last_s     = (sc_q == SC_LAST) && (bc_q == BC_LAST);
  assign next_bit_s = (sc_q == SC_LAST) ? shreg_q[MSG_W-2] : shreg_q[MSG_W-1];

  // Frame FSM. phase_q always holds the phase of the sample to be shown next,
  // and is 0 outside RUN so the launch sample reads the table at phase 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_ASK;
      shreg_q   <= '0;
      sc_q      <= '0;
      bc_q      <= '0;
      phase_q   <= '0;
      out_q     <= MID;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_out_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          sc_q <= '0;
          bc_q <= '0;
          if (launch_s) begin
            state_q   <= ST_RUN;
            mode_q    <= mode;
            shreg_q   <= msg;
            phase_q   <= phase_inc(mode, msg[MSG_W-1]);
            out_q     <= shape_sample(mode, msg[MSG_W-1], lut_s);
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            bit_out_q <= msg[MSG_W-1];
          end else begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            out_q     <= MID;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_out_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (last_s) begin
            state_q   <= ST_DONE;
            sc_q      <= '0;
            bc_q      <= '0;
            phase_q   <= '0;
            out_q     <= MID;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            bit_out_q <= 1'b0;
          end else begin
            if (sc_q == SC_LAST) begin
              sc_q    <= '0;
              bc_q    <= bc_q + 1'b1;
              shreg_q <= shreg_q << 1;
            end else begin
              sc_q    <= sc_q + 1'b1;
            end
            phase_q   <= phase_q + phase_inc(mode_q, next_bit_s);
            out_q     <= shape_sample(mode_q, next_bit_s, lut_s);
            bit_out_q <= next_bit_s;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          phase_q   <= '0;
          out_q     <= MID;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          bit_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_out = bit_out_q;

endmodule

// File: tb/tb_param_modulator.sv
// Randomized self-checking bench for param_modulator against a frame-level model.
module tb_param_modulator;

  localparam int MSG_W  = 10;
  localparam int OUT_W  = 8;
  localparam int SPS    = 16;
  localparam int LUT_AW = 6;
  localparam int INC_F0 = 1;
  localparam int INC_F1 = 2;
  localparam int NS     = MSG_W * SPS;
  localparam int DEPTH  = 64;
  localparam int MID    = 128;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [MSG_W-1:0] msg;
  logic [1:0]       mode;
  logic [OUT_W-1:0] out;
  logic             busy;
  logic             done;
  logic             bit_out;

  int total = 0;
  int bad   = 0;
  int exp_out [NS];
  int exp_bit [NS];

  always #5 clk = ~clk;

  param_modulator #(
    .MSG_W(MSG_W), .OUT_W(OUT_W), .SPS(SPS), .LUT_AW(LUT_AW),
    .INC_F0(INC_F0), .INC_F1(INC_F1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .msg(msg), .mode(mode),
    .out(out), .busy(busy), .done(done), .bit_out(bit_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sine_val(input int ph);
    return $rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979323846 * real'(ph) / real'(DEPTH)) + 0.5);
  endfunction

  // Whole-frame expectation: bit per symbol, phase accumulating sample by sample.
  function automatic void build_model(input logic [1:0] md, input logic [MSG_W-1:0] m);
    int ph;
    int s;
    int b;
    ph = 0;
    for (int k = 0; k < NS; k++) begin
      b = int'(m[MSG_W-1-k/SPS]);
      s = sine_val(ph);
      case (md)
        2'b00:   exp_out[k] = (b == 1) ? s : MID;
        2'b01:   exp_out[k] = s;
        2'b10:   exp_out[k] = (b == 1) ? s : 255 - s;
        default: exp_out[k] = MID;
      endcase
      exp_bit[k] = b;
      if (md == 2'b01) ph = (ph + ((b == 1) ? INC_F1 : INC_F0)) % DEPTH;
      else             ph = (ph + 1) % DEPTH;
    end
  endfunction

  // Called at a negedge; the next posedge samples start and the frame runs.
  task automatic run_frame(input logic [1:0] md, input logic [MSG_W-1:0] m,
                           input bit hold, input bit chg);
    start = 1'b1;
    msg   = m;
    mode  = md;
    build_model(md, m);
    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      chk($sformatf("busy[%0d]", k), 32'(busy), 32'd1);
      chk($sformatf("out[%0d]", k), 32'(out), 32'(exp_out[k]));
      chk($sformatf("bit[%0d]", k), 32'(bit_out), 32'(exp_bit[k]));
      chk($sformatf("done_run[%0d]", k), 32'(done), 32'd0);
      if (k == 0 && !hold) start = 1'b0;
      if (chg && k == 4) begin
        msg  = ~m;
        mode = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("out_done", 32'(out), 32'(MID));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_out", 32'(out), 32'(MID));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    msg   = '0;
    mode  = 2'b00;
    #1 rst = 1'b0;
    #1;
    chk("rst_out", 32'(out), 32'(MID));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bit", 32'(bit_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    start = 1'b0;
    run_frame(2'b00, 10'b1000110101, 1'b0, 1'b0);
    start = 1'b0;
    idle(2);
    run_frame(2'b10, 10'b1111111111, 1'b0, 1'b0);
    start = 1'b0;
    idle(1);
    run_frame(2'b10, 10'b0000000000, 1'b0, 1'b0);
    start = 1'b0;
    idle(1);
    run_frame(2'b01, 10'b1010101010, 1'b0, 1'b0);
    start = 1'b0;
    idle(1);

`ifndef PARAM_MODULATOR_REPEAT_EN
    // Held start with msg/mode changed mid-frame: one frame, then no re-launch.
    run_frame(2'b00, 10'b1100101101, 1'b1, 1'b1);
    idle(20);
    start = 1'b0;
    idle(1);
    run_frame(2'b01, 10'b0110011001, 1'b0, 1'b1);
    start = 1'b0;
    idle(1);
`else
    // Held start chains frames; each done cycle is the only busy-low cycle.
    run_frame(2'b00, 10'b1100101101, 1'b1, 1'b1);
    run_frame(2'b10, 10'b0011010110, 1'b1, 1'b0);
    run_frame(2'b01, 10'b1110001011, 1'b1, 1'b0);
    start = 1'b0;
    idle(2);
`endif

    // Asynchronous reset in the middle of a frame.
    start = 1'b1;
    msg   = 10'b1111111111;
    mode  = 2'b00;
    for (int k = 0; k < 7; k++) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_out", 32'(out), 32'(MID));
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_bit", 32'(bit_out), 32'd0);
    @(negedge clk);
    start = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);
    run_frame(2'b01, 10'b1001011100, 1'b0, 1'b0);
    start = 1'b0;
    idle(1);

    for (int f = 0; f < 6; f++) begin
      run_frame(2'($urandom_range(0, 3)), MSG_W'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      start = 1'b0;
      idle(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
